// File: rtl/reg_dump_engine.sv
// -----------------------------------------------------------------------------
// reg_dump_engine
//
// Purpose:
//   On each rising edge of the CPU halt line, walks the CPU register file
//   through a single read port and streams every register out as an
//   {index, data} beat on a valid/ready port (for a UART or trace sink).
//   Each beat takes three cycles (READ, CAPT, SEND) when the sink is always
//   ready, and dump_valid drops for at least one cycle between beats.
//
// Optional feature (compile-time macro DUMP_CHECKSUM_EN):
//   When defined, a running XOR of all register values in the current dump is
//   kept and emitted as one extra beat with dump_idx = NUM_REGS after the last
//   register. dump_last then marks only that checksum beat. When undefined,
//   there is no checksum state or register, and dump_last marks register
//   NUM_REGS-1.
//
// Parameters:
//   NUM_REGS  registers dumped, indices 0..NUM_REGS-1 (>= 2)
//   DATA_W    register width in bits
//   IDX_W     index width; 2**IDX_W must exceed NUM_REGS
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   halt        in   CPU halt level; a rising edge requests a dump
//   rf_re       out  register-file read enable (one-cycle pulse per register)
//   rf_raddr    out  register-file read address
//   rf_rdata    in   register-file read data, valid the cycle after rf_re
//   dump_valid  out  beat valid
//   dump_ready  in   sink ready
//   dump_idx    out  register index of the beat
//   dump_data   out  register value of the beat
//   dump_last   out  final beat of the dump
//   busy        out  dump in progress
//   overrun     out  sticky: a halt rise was dropped (pending already full)
// -----------------------------------------------------------------------------
module reg_dump_engine #(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 8,
    parameter int IDX_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt,
    output logic              rf_re,
    output logic [IDX_W-1:0]  rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [IDX_W-1:0]  dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    output logic              busy,
    output logic              overrun
);

`ifdef DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_CAPT = 3'd2,
        S_SEND = 3'd3,
        S_CSUM = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_CAPT = 2'd2,
        S_SEND = 2'd3
    } state_t;
`endif

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
`ifdef DUMP_CHECKSUM_EN
    localparam logic [IDX_W-1:0] CSUM_IDX = IDX_W'(NUM_REGS);
`endif

    state_t              state_q, state_d;
    logic                halt_q;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                pending_q, pending_d;
    logic                overrun_q, overrun_d;
    logic                valid_q, valid_d;
    logic [IDX_W-1:0]    didx_q, didx_d;
    logic [DATA_W-1:0]   ddata_q, ddata_d;
    logic                last_q, last_d;
`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0]   csum_q, csum_d;
`endif

    logic rise;
    logic xfer;
    logic finish;
    logic consume;

    assign rise = halt & ~halt_q;
    assign xfer = valid_q & dump_ready;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        valid_d   = valid_q;
        didx_d    = didx_q;
        ddata_d   = ddata_q;
        last_d    = last_q;
`ifdef DUMP_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        finish    = 1'b0;
        consume   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rise || pending_q) begin
                    state_d = S_READ;
                    idx_d   = '0;
                    consume = 1'b1;
`ifdef DUMP_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            S_READ: begin
                state_d = S_CAPT;
            end
            S_CAPT: begin
                ddata_d = rf_rdata;
                didx_d  = idx_q;
                valid_d = 1'b1;
                state_d = S_SEND;
`ifdef DUMP_CHECKSUM_EN
                csum_d  = csum_q ^ rf_rdata;
                last_d  = 1'b0;
`else
                last_d  = (idx_q == LAST_IDX);
`endif
            end
            S_SEND: begin
                if (xfer) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (idx_q != LAST_IDX) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_READ;
                    end else begin
`ifdef DUMP_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        finish  = 1'b1;
`endif
                    end
                end
            end
`ifdef DUMP_CHECKSUM_EN
            S_CSUM: begin
                // First CSUM cycle is the mandatory gap after the last
                // register beat; the checksum beat is loaded here.
                if (!valid_q) begin
                    didx_d  = CSUM_IDX;
                    ddata_d = csum_q;
                    last_d  = 1'b1;
                    valid_d = 1'b1;
                end else if (xfer) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    finish  = 1'b1;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A queued request restarts straight from the end of the current
        // dump so busy never dips between back-to-back dumps.
        if (finish) begin
            if (pending_q) begin
                state_d = S_READ;
                idx_d   = '0;
                consume = 1'b1;
`ifdef DUMP_CHECKSUM_EN
                csum_d  = '0;
`endif
            end else begin
                state_d = S_IDLE;
            end
        end

        if (consume) begin
            pending_d = 1'b0;
        end

        // In IDLE a rise starts the dump directly. While busy it queues one
        // request; the queue slot is free again if it is consumed this edge.
        if (rise && (state_q != S_IDLE)) begin
            if (!pending_q || consume) begin
                pending_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            // Reset to 1 so a halt that is already high at release is not
            // mistaken for a rising edge.
            halt_q    <= 1'b1;
            idx_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            valid_q   <= 1'b0;
            didx_q    <= '0;
            ddata_q   <= '0;
            last_q    <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            halt_q    <= halt;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            valid_q   <= valid_d;
            didx_q    <= didx_d;
            ddata_q   <= ddata_d;
            last_q    <= last_d;
`ifdef DUMP_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    assign rf_re      = (state_q == S_READ);
    assign rf_raddr   = idx_q;
    assign dump_valid = valid_q;
    assign dump_idx   = didx_q;
    assign dump_data  = ddata_q;
    assign dump_last  = last_q;
    assign busy       = (state_q != S_IDLE);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_reg_dump_engine.sv
module tb_reg_dump_engine;

    localparam int NUM_REGS = 8;
    localparam int DATA_W   = 8;
    localparam int IDX_W    = 4;
`ifdef DUMP_CHECKSUM_EN
    localparam int BPD = NUM_REGS + 1;
`else
    localparam int BPD = NUM_REGS;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              halt;
    logic              rf_re;
    logic [IDX_W-1:0]  rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic              dump_valid;
    logic              dump_ready;
    logic [IDX_W-1:0]  dump_idx;
    logic [DATA_W-1:0] dump_data;
    logic              dump_last;
    logic              busy;
    logic              overrun;

    logic [63:0]       rf_flat;

    int tests = 0;
    int fails = 0;

    reg_dump_engine #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .halt       (halt),
        .rf_re      (rf_re),
        .rf_raddr   (rf_raddr),
        .rf_rdata   (rf_rdata),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_last  (dump_last),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Register file model: synchronous read, data the cycle after rf_re.
    always @(posedge clk) begin
        if (rf_re) rf_rdata <= rf_flat[int'(rf_raddr)*8 +: 8];
    end

    typedef struct {
        logic [63:0] rf;        // byte i = register i
        int          stall_idx; // beat held with ready=0 (-1: none)
        int          stall_len;
        int          extra;     // extra halt rises during first dump
        logic [7:0]  csum;
        int          cyc;       // busy cycles without checksum
        int          cyc_cs;    // busy cycles with checksum
        logic        ovr;
    } row_t;

    row_t tbl [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_row(input int rn, input row_t r);
        int beats, cyc, dips, rfre_bad, raddr_bad, stall_ctr, budget, exp_beats, idle_busy;
        int lcl, dn, exp_cyc;
        bit seen, halt_restore;
        logic [7:0] ed;
        rf_flat    = r.rf;
        dump_ready = 1'b1;
        halt       = 1'b0;
        repeat (2) @(negedge clk);
        halt = 1'b1;
        beats = 0; cyc = 0; dips = 0; rfre_bad = 0; raddr_bad = 0;
        stall_ctr = 0; budget = 0; seen = 0; halt_restore = 0;
        exp_beats = (r.extra >= 1) ? 2 * BPD : BPD;
        while (budget < 400) begin
            @(negedge clk);
            budget++;
            if (busy) cyc++;
            else if (beats < exp_beats) dips++;
            if (rf_re && dump_valid) rfre_bad++;
            if (rf_re && (int'(rf_raddr) >= NUM_REGS)) raddr_bad++;
            if (halt_restore) begin
                halt = 1'b1;
                halt_restore = 0;
            end
            if (dump_valid) begin
                lcl = beats % BPD;
                dn  = beats / BPD;
                ed  = (lcl < NUM_REGS) ? r.rf[lcl*8 +: 8] : r.csum;
                check($sformatf("r%0d_b%0d_idx", rn, beats), 32'(dump_idx), 32'(lcl));
                check($sformatf("r%0d_b%0d_data", rn, beats), 32'(dump_data), 32'(ed));
                check($sformatf("r%0d_b%0d_last", rn, beats), 32'(dump_last), 32'(lcl == BPD - 1));
                if (!seen && dn == 0 && ((r.extra >= 1 && lcl == 2) || (r.extra >= 2 && lcl == 4))) begin
                    halt = 1'b0;
                    halt_restore = 1;
                end
                if (dn == 0 && lcl == r.stall_idx && stall_ctr < r.stall_len) begin
                    dump_ready = 1'b0;
                    stall_ctr++;
                    seen = 1;
                end else begin
                    dump_ready = 1'b1;
                    beats++;
                    seen = 0;
                end
            end
            if (beats == exp_beats && !busy) break;
        end
        check($sformatf("r%0d_done", rn), 32'(beats == exp_beats && !busy), 32'd1);
`ifdef DUMP_CHECKSUM_EN
        exp_cyc = r.cyc_cs;
`else
        exp_cyc = r.cyc;
`endif
        check($sformatf("r%0d_cycles", rn), 32'(cyc), 32'(exp_cyc));
        check($sformatf("r%0d_busy_dips", rn), 32'(dips), 32'd0);
        check($sformatf("r%0d_rfre_in_send", rn), 32'(rfre_bad), 32'd0);
        check($sformatf("r%0d_raddr_range", rn), 32'(raddr_bad), 32'd0);
        idle_busy = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy || dump_valid) idle_busy++;
        end
        check($sformatf("r%0d_no_extra_dump", rn), 32'(idle_busy), 32'd0);
        check($sformatf("r%0d_overrun", rn), 32'(overrun), 32'(r.ovr));
    endtask

    initial begin
        int n, guard;
        tbl[0] = '{64'h8040201008040201, -1, 0, 0, 8'hFF, 24, 26, 1'b0};
        tbl[1] = '{64'h8040201008040201,  3, 5, 0, 8'hFF, 29, 31, 1'b0};
        tbl[2] = '{64'hE011C33CFF005AA5, -1, 0, 1, 8'h0E, 48, 52, 1'b0};
        tbl[3] = '{64'hF1DEBC9A78563412, -1, 0, 2, 8'h01, 48, 52, 1'b1};

        rf_flat    = 64'h0;
        halt       = 1'b1;
        dump_ready = 1'b1;
        reset      = 1'b1;
        #3 reset = 1'b0;

        // Reset held with halt high: everything quiet.
        repeat (3) @(negedge clk);
        check("rst_rf_re", 32'(rf_re), 32'd0);
        check("rst_rf_raddr", 32'(rf_raddr), 32'd0);
        check("rst_valid", 32'(dump_valid), 32'd0);
        check("rst_idx", 32'(dump_idx), 32'd0);
        check("rst_data", 32'(dump_data), 32'd0);
        check("rst_last", 32'(dump_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);

        // Release with halt already high: no rise, no dump.
        reset = 1'b1;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy || rf_re || dump_valid) n++;
        end
        check("no_dump_after_release", 32'(n), 32'd0);

        for (int i = 0; i < 4; i++) run_row(i, tbl[i]);

        // Reset mid-dump at beat idx5, then a fresh dump from idx0.
        rf_flat = tbl[0].rf;
        halt = 1'b0;
        repeat (2) @(negedge clk);
        halt = 1'b1;
        guard = 0;
        while (!(dump_valid && dump_idx == 4'd5) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("reach_idx5", 32'(dump_valid && dump_idx == 4'd5), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(dump_valid), 32'd0);
        check("abort_rf_re", 32'(rf_re), 32'd0);
        check("abort_overrun_clr", 32'(overrun), 32'd0);
        reset = 1'b1;
        run_row(4, tbl[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
